seq_multicycle: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle processor top.
- Executes the same 32-bit, 6-bit-opcode MIPS-style instruction format, but one instruction is spread over 3–5 clock states. A single shared ALU serves every state, and a run gate allows stepping.
- Contains its own instruction memory (program-loadable), data memory and register file.
- Exposes the same debug observation outputs plus FSM status.

---
 rtl/seq_pkg.sv | 57 +++++
 rtl/seq_regfile.sv | 36 +++
 rtl/seq_multicycle.sv | 216 +++++++++++++++++++++
 tb/tb_seq_multicycle.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the multi-cycle processor: opcodes, FSM states,
// ALU operation codes and the opcode classification helpers.
package seq_pkg;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_AND  = 6'b010000;
    localparam logic [5:0] OP_OR   = 6'b010001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_t;

    // Address arithmetic (ADDI, LW, SW, BEQ target) all falls through to ADD.
    function automatic alu_op_t alu_op_of(input logic [5:0] op);
        case (op)
            OP_SUB:        return ALU_SUB;
            OP_AND:        return ALU_AND;
            OP_OR, OP_ORI: return ALU_OR;
            default:       return ALU_ADD;
        endcase
    endfunction

    function automatic logic is_rtype(input logic [5:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic is_itype(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ORI);
    endfunction

    // Anything not in the instruction set retires from DECODE as a NOP.
    function automatic logic is_nop(input logic [5:0] op);
        return !(is_rtype(op) || is_itype(op) || (op == OP_SW) || (op == OP_LW) ||
                 (op == OP_BEQ) || (op == OP_J) || (op == OP_HALT));
    endfunction

endpackage

// File: rtl/seq_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// asynchronous active-low clear, register 0 hardwired to zero.
module seq_regfile
    import seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(NREGS)-1:0] raddr_a,
    input  logic [$clog2(NREGS)-1:0] raddr_b,
    output logic [XLEN-1:0]          rdata_a,
    output logic [XLEN-1:0]          rdata_b,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] waddr,
    input  logic [XLEN-1:0]          wdata
);

    logic [XLEN-1:0] regs [NREGS];

    // Clear every register on reset; writes to register 0 are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/seq_multicycle.sv
// Multi-cycle MIPS-style processor: one shared ALU, a FETCH/DECODE/EXEC/
// MEM/WB sequencer, program-loadable instruction memory and data memory.
module seq_multicycle
    import seq_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NREGS      = 32,
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          run,
    input  logic                          prog_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
    input  logic [31:0]                   prog_data,
    output logic [XLEN-1:0]               pc_out,
    output logic [31:0]                   instr_out,
    output logic [XLEN-1:0]               alu_out,
    output logic [XLEN-1:0]               memdata_out,
    output logic [2:0]                    state_out,
    output logic                          instr_done,
    output logic                          halted
);

    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);
    localparam int RAW = $clog2(NREGS);

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [31:0]     ir;
    logic [XLEN-1:0] a_reg;
    logic [XLEN-1:0] b_reg;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] mdr;

    logic [31:0]     imem [IMEM_DEPTH];
    logic [XLEN-1:0] dmem [DMEM_DEPTH];

    // Instruction fields (register indices keep only the bits NREGS needs).
    logic [5:0]      op;
    logic [RAW-1:0]  rs_idx;
    logic [RAW-1:0]  rt_idx;
    logic [RAW-1:0]  rd_idx;
    logic [XLEN-1:0] sext_imm;
    logic [XLEN-1:0] zext_imm;

    assign op       = ir[31:26];
    assign rs_idx   = ir[21 +: RAW];
    assign rt_idx   = ir[16 +: RAW];
    assign rd_idx   = ir[11 +: RAW];
    assign sext_imm = {{(XLEN-16){ir[15]}}, ir[15:0]};
    assign zext_imm = {{(XLEN-16){1'b0}}, ir[15:0]};

    // Word indices: low two byte bits and bits above the memory span ignored.
    logic [IAW-1:0] fetch_idx;
    logic [DAW-1:0] data_idx;

    assign fetch_idx = pc[IAW+1:2];
    assign data_idx  = alu_q[DAW+1:2];

    // Register file.
    logic [XLEN-1:0] rf_a;
    logic [XLEN-1:0] rf_b;
    logic            rf_we;
    logic [RAW-1:0]  rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    assign rf_we    = (state == ST_WB) && (is_rtype(op) || is_itype(op) || (op == OP_LW));
    assign rf_waddr = is_rtype(op) ? rd_idx : rt_idx;
    assign rf_wdata = (op == OP_LW) ? mdr : alu_q;

    seq_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_rf (
        .clk     (CLK),
        .rst_n   (RESET),
        .raddr_a (rs_idx),
        .raddr_b (rt_idx),
        .rdata_a (rf_a),
        .rdata_b (rf_b),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata)
    );

    // Shared ALU operand select: PC+4 in FETCH, instruction operation in EXEC.
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    alu_op_t         alu_op;
    logic [XLEN-1:0] alu_y;

    always_comb begin
        alu_a  = a_reg;
        alu_b  = b_reg;
        alu_op = alu_op_of(op);
        if (state == ST_FETCH) begin
            alu_a  = pc;
            alu_b  = XLEN'(4);
            alu_op = ALU_ADD;
        end else if (op == OP_BEQ) begin
            alu_a  = pc;
            alu_b  = {sext_imm[XLEN-3:0], 2'b00};
            alu_op = ALU_ADD;
        end else if (op == OP_ORI) begin
            alu_b = zext_imm;
        end else if ((op == OP_ADDI) || (op == OP_LW) || (op == OP_SW)) begin
            alu_b = sext_imm;
        end
    end

    // ALU datapath, arithmetic modulo 2^XLEN.
    always_comb begin
        case (alu_op)
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            default: alu_y = alu_a + alu_b;
        endcase
    end

    // Retirement pulse: asserted during the state whose closing edge ends the instruction.
    always_comb begin
        case (state)
            ST_DECODE: instr_done = is_nop(op);
            ST_EXEC:   instr_done = (op == OP_BEQ) || (op == OP_J);
            ST_MEM:    instr_done = (op == OP_SW);
            ST_WB:     instr_done = 1'b1;
            default:   instr_done = 1'b0;
        endcase
    end

    // Program loading; a fetch on the same edge still reads the previous word.
    always_ff @(posedge CLK) begin
        if (prog_we) begin
            imem[prog_addr] <= prog_data;
        end
    end

    // Store path; state is reset asynchronously so a reset edge never stores.
    always_ff @(posedge CLK) begin
        if ((state == ST_MEM) && (op == OP_SW)) begin
            dmem[data_idx] <= b_reg;
        end
    end

    // Instruction sequencer and architectural registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= ST_FETCH;
            pc    <= '0;
            ir    <= '0;
            a_reg <= '0;
            b_reg <= '0;
            alu_q <= '0;
            mdr   <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (run) begin
                        ir    <= imem[fetch_idx];
                        pc    <= alu_y;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    a_reg <= rf_a;
                    b_reg <= rf_b;
                    if (op == OP_HALT) begin
                        state <= ST_HALT;
                    end else if (is_nop(op)) begin
                        state <= ST_FETCH;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    alu_q <= alu_y;
                    if (is_rtype(op) || is_itype(op)) begin
                        state <= ST_WB;
                    end else if ((op == OP_LW) || (op == OP_SW)) begin
                        state <= ST_MEM;
                    end else begin
                        if ((op == OP_BEQ) && (a_reg == b_reg)) begin
                            pc <= alu_y;
                        end else if (op == OP_J) begin
                            pc <= {pc[XLEN-1:28], ir[25:0], 2'b00};
                        end
                        state <= ST_FETCH;
                    end
                end
                ST_MEM: begin
                    if (op == OP_LW) begin
                        mdr   <= dmem[data_idx];
                        state <= ST_WB;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                ST_WB:   state <= ST_FETCH;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_FETCH;
            endcase
        end
    end

    assign pc_out      = pc;
    assign instr_out   = ir;
    assign alu_out     = alu_q;
    assign memdata_out = mdr;
    assign state_out   = state;
    assign halted      = (state == ST_HALT);

endmodule

// File: tb/tb_seq_multicycle.sv
// Directed testbench for seq_multicycle: small programs with hand-computed
// register, memory and timing expectations.
module tb_seq_multicycle;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        run = 1'b0;
    logic        prog_we = 1'b0;
    logic [7:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic [31:0] alu_out;
    logic [31:0] memdata_out;
    logic [2:0]  state_out;
    logic        instr_done;
    logic        halted;

    int checks = 0;
    int errors = 0;

    logic [31:0] prog_q[$];

    seq_multicycle dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .run         (run),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .pc_out      (pc_out),
        .instr_out   (instr_out),
        .alu_out     (alu_out),
        .memdata_out (memdata_out),
        .state_out   (state_out),
        .instr_done  (instr_done),
        .halted      (halted)
    );

    // Clock: 10 time-unit period.
    always #5 CLK = ~CLK;

    // Encoders.
    function automatic logic [31:0] r_ins(input logic [5:0] op, input int rs, input int rt, input int rd);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'b0};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    localparam logic [31:0] HALT_W = {6'b111111, 26'b0};

    // Driver tasks: all input changes happen at the falling edge.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Hold reset, load prog_q from word 0, then release reset with run as given.
    task automatic start_prog(input logic run_val);
        RESET = 1'b0;
        run   = 1'b0;
        tick();
        for (int i = 0; i < prog_q.size(); i++) begin
            prog_addr = 8'(i);
            prog_data = prog_q[i];
            prog_we   = 1'b1;
            tick();
        end
        prog_we = 1'b0;
        prog_q.delete();
        run   = run_val;
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        run   = 1'b1;
        ticks(3);
        checks++; if (pc_out !== 32'd0) begin errors++; $display("FAIL reset_pc got %h want 0", pc_out); end
        checks++; if (instr_out !== 32'd0) begin errors++; $display("FAIL reset_ir got %h want 0", instr_out); end
        checks++; if (alu_out !== 32'd0) begin errors++; $display("FAIL reset_alu got %h want 0", alu_out); end
        checks++; if (memdata_out !== 32'd0) begin errors++; $display("FAIL reset_mdr got %h want 0", memdata_out); end
        checks++; if (state_out !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_out); end
        checks++; if (instr_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", instr_done); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
    endtask

    // ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2; HALT
    task automatic test_basic();
        logic exp_done;
        prog_q = '{i_ins(6'b000010, 0, 1, 16'd5), i_ins(6'b000010, 0, 2, 16'hFFFD),
                   r_ins(6'b000000, 1, 2, 3), HALT_W};
        start_prog(1'b1);
        for (int cyc = 1; cyc <= 16; cyc++) begin
            exp_done = (cyc == 4) || (cyc == 8) || (cyc == 12);
            checks++; if (instr_done !== exp_done) begin errors++; $display("FAIL basic_done cyc %0d got %b want %b", cyc, instr_done, exp_done); end
            tick();
            if (cyc == 11) begin
                checks++; if (alu_out !== 32'd2) begin errors++; $display("FAIL basic_alu got %h want 2", alu_out); end
            end
            if (cyc == 12) begin
                checks++; if (dut.u_rf.regs[3] !== 32'd2) begin errors++; $display("FAIL basic_r3 got %h want 2", dut.u_rf.regs[3]); end
                checks++; if (dut.u_rf.regs[2] !== 32'hFFFFFFFD) begin errors++; $display("FAIL basic_r2 got %h want fffffffd", dut.u_rf.regs[2]); end
            end
            checks++; if (halted !== (cyc >= 14)) begin errors++; $display("FAIL basic_halted cyc %0d got %b", cyc, halted); end
            if (cyc >= 14) begin
                checks++; if (pc_out !== 32'd16) begin errors++; $display("FAIL basic_pc cyc %0d got %h want 10", cyc, pc_out); end
            end
        end
    endtask

    // Build 0xDEADBEEF in r1, SW r1,8(r0), then LW r4,8(r0) cycle by cycle.
    task automatic test_sw_lw();
        logic [2:0] exp_state [5];
        exp_state = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        prog_q.push_back(i_ins(6'b010010, 0, 1, 16'hDEAD));
        for (int i = 0; i < 16; i++) prog_q.push_back(r_ins(6'b000000, 1, 1, 1));
        prog_q.push_back(i_ins(6'b010010, 1, 1, 16'hBEEF));
        prog_q.push_back(i_ins(6'b100110, 0, 1, 16'd8));
        prog_q.push_back(i_ins(6'b100111, 0, 4, 16'd8));
        prog_q.push_back(HALT_W);
        start_prog(1'b1);
        ticks(76);
        checks++; if (dut.u_rf.regs[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL swlw_r1 got %h want deadbeef", dut.u_rf.regs[1]); end
        checks++; if (dut.dmem[2] !== 32'hDEADBEEF) begin errors++; $display("FAIL swlw_dmem got %h want deadbeef", dut.dmem[2]); end
        for (int k = 1; k <= 5; k++) begin
            checks++; if (instr_done !== (k == 5)) begin errors++; $display("FAIL lw_done k %0d got %b", k, instr_done); end
            tick();
            checks++; if (state_out !== exp_state[k-1]) begin errors++; $display("FAIL lw_state k %0d got %0d want %0d", k, state_out, exp_state[k-1]); end
        end
        checks++; if (memdata_out !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_mdr got %h want deadbeef", memdata_out); end
        checks++; if (dut.u_rf.regs[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_r4 got %h want deadbeef", dut.u_rf.regs[4]); end
        checks++; if (pc_out !== 32'd80) begin errors++; $display("FAIL lw_pc got %h want 50", pc_out); end
    endtask

    // 0: BEQ r1,r2,+2  1: HALT  2: HALT  3: ADDI r1,r0,1  4: J 0
    task automatic test_branch();
        prog_q = '{i_ins(6'b110000, 1, 2, 16'd2), HALT_W, HALT_W,
                   i_ins(6'b000010, 0, 1, 16'd1), {6'b111000, 26'd0}};
        start_prog(1'b1);
        ticks(2);
        checks++; if (instr_done !== 1'b1) begin errors++; $display("FAIL beq_done got %b want 1", instr_done); end
        tick();
        checks++; if (pc_out !== 32'd12) begin errors++; $display("FAIL beq_taken_pc got %h want c", pc_out); end
        checks++; if (state_out !== 3'd0) begin errors++; $display("FAIL beq_state got %0d want 0", state_out); end
        ticks(4);
        checks++; if (pc_out !== 32'd16) begin errors++; $display("FAIL addi_pc got %h want 10", pc_out); end
        ticks(3);
        checks++; if (pc_out !== 32'd0) begin errors++; $display("FAIL j_pc got %h want 0", pc_out); end
        ticks(3);
        checks++; if (pc_out !== 32'd4) begin errors++; $display("FAIL beq_not_taken_pc got %h want 4", pc_out); end
        ticks(2);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL branch_halt got %b want 1", halted); end
    endtask

    // run=0 holds FETCH; raising run resumes.
    task automatic test_run_gate();
        prog_q = '{i_ins(6'b000010, 0, 1, 16'd9), HALT_W};
        start_prog(1'b0);
        for (int c = 0; c < 10; c++) begin
            checks++; if (instr_done !== 1'b0) begin errors++; $display("FAIL gate_done c %0d got %b", c, instr_done); end
            tick();
            checks++; if (state_out !== 3'd0) begin errors++; $display("FAIL gate_state c %0d got %0d", c, state_out); end
            checks++; if (pc_out !== 32'd0) begin errors++; $display("FAIL gate_pc c %0d got %h", c, pc_out); end
        end
        run = 1'b1;
        ticks(4);
        checks++; if (dut.u_rf.regs[1] !== 32'd9) begin errors++; $display("FAIL gate_r1 got %h want 9", dut.u_rf.regs[1]); end
        checks++; if (pc_out !== 32'd4) begin errors++; $display("FAIL gate_pc_resume got %h want 4", pc_out); end
        ticks(2);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL gate_halt got %b want 1", halted); end
    endtask

    // Reset asserted while the second SW sits in MEM.
    task automatic test_reset_mid_mem();
        prog_q = '{i_ins(6'b000010, 0, 1, 16'h0055), i_ins(6'b100110, 0, 1, 16'd8),
                   i_ins(6'b000010, 0, 1, 16'h0066), i_ins(6'b100110, 0, 1, 16'd8), HALT_W};
        start_prog(1'b1);
        ticks(8);
        checks++; if (dut.dmem[2] !== 32'h55) begin errors++; $display("FAIL mid_first_sw got %h want 55", dut.dmem[2]); end
        ticks(7);
        checks++; if (state_out !== 3'd3) begin errors++; $display("FAIL mid_in_mem got %0d want 3", state_out); end
        #1 RESET = 1'b0;
        #1;
        checks++; if (pc_out !== 32'd0) begin errors++; $display("FAIL mid_async_pc got %h want 0", pc_out); end
        checks++; if (instr_out !== 32'd0) begin errors++; $display("FAIL mid_async_ir got %h want 0", instr_out); end
        checks++; if (alu_out !== 32'd0) begin errors++; $display("FAIL mid_async_alu got %h want 0", alu_out); end
        checks++; if (state_out !== 3'd0) begin errors++; $display("FAIL mid_async_state got %0d want 0", state_out); end
        checks++; if (instr_done !== 1'b0) begin errors++; $display("FAIL mid_async_done got %b want 0", instr_done); end
        tick();
        checks++; if (dut.dmem[2] !== 32'h55) begin errors++; $display("FAIL mid_no_store got %h want 55", dut.dmem[2]); end
        checks++; if (dut.u_rf.regs[1] !== 32'd0) begin errors++; $display("FAIL mid_r1_clear got %h want 0", dut.u_rf.regs[1]); end
        RESET = 1'b1;
        tick();
        checks++; if (pc_out !== 32'd4) begin errors++; $display("FAIL mid_restart_pc got %h want 4", pc_out); end
        checks++; if (instr_out !== 32'h08010055) begin errors++; $display("FAIL mid_restart_ir got %h want 08010055", instr_out); end
    endtask

    // Register 0 discards writes; an illegal opcode is a 2-cycle NOP.
    task automatic test_r0_nop();
        prog_q = '{i_ins(6'b000010, 0, 5, 16'd3), i_ins(6'b000010, 0, 0, 16'd7),
                   r_ins(6'b000000, 0, 0, 5), i_ins(6'b101010, 1, 6, 16'd1), HALT_W};
        start_prog(1'b1);
        ticks(4);
        checks++; if (dut.u_rf.regs[5] !== 32'd3) begin errors++; $display("FAIL r0_r5_pre got %h want 3", dut.u_rf.regs[5]); end
        ticks(3);
        checks++; if (alu_out !== 32'd7) begin errors++; $display("FAIL r0_addi_alu got %h want 7", alu_out); end
        ticks(4);
        checks++; if (alu_out !== 32'd0) begin errors++; $display("FAIL r0_add_alu got %h want 0", alu_out); end
        tick();
        checks++; if (dut.u_rf.regs[5] !== 32'd0) begin errors++; $display("FAIL r0_r5 got %h want 0", dut.u_rf.regs[5]); end
        tick();
        checks++; if (instr_done !== 1'b1) begin errors++; $display("FAIL nop_done got %b want 1", instr_done); end
        tick();
        checks++; if (state_out !== 3'd0) begin errors++; $display("FAIL nop_state got %0d want 0", state_out); end
        checks++; if (pc_out !== 32'd16) begin errors++; $display("FAIL nop_pc got %h want 10", pc_out); end
        checks++; if (dut.u_rf.regs[6] !== 32'd0) begin errors++; $display("FAIL nop_r6 got %h want 0", dut.u_rf.regs[6]); end
        checks++; if (dut.u_rf.regs[1] !== 32'd0) begin errors++; $display("FAIL nop_r1 got %h want 0", dut.u_rf.regs[1]); end
    endtask

    // ORI zero-extends; SUB/AND/OR back to back.
    task automatic test_alu_ops();
        prog_q = '{i_ins(6'b010010, 0, 1, 16'hF0F0), i_ins(6'b000010, 0, 2, 16'h0FF0),
                   r_ins(6'b010000, 1, 2, 3), r_ins(6'b010001, 1, 2, 4),
                   r_ins(6'b000001, 2, 1, 5), HALT_W};
        start_prog(1'b1);
        ticks(20);
        checks++; if (dut.u_rf.regs[1] !== 32'h0000F0F0) begin errors++; $display("FAIL ori_r1 got %h want 0000f0f0", dut.u_rf.regs[1]); end
        checks++; if (dut.u_rf.regs[3] !== 32'h000000F0) begin errors++; $display("FAIL and_r3 got %h want 000000f0", dut.u_rf.regs[3]); end
        checks++; if (dut.u_rf.regs[4] !== 32'h0000FFF0) begin errors++; $display("FAIL or_r4 got %h want 0000fff0", dut.u_rf.regs[4]); end
        checks++; if (dut.u_rf.regs[5] !== 32'hFFFF1F00) begin errors++; $display("FAIL sub_r5 got %h want ffff1f00", dut.u_rf.regs[5]); end
    endtask

    // Writing the word being fetched on the same edge: fetch sees the old word.
    task automatic test_prog_collision();
        prog_q = '{i_ins(6'b000010, 0, 1, 16'd1), HALT_W};
        start_prog(1'b1);
        prog_addr = 8'd0;
        prog_data = i_ins(6'b000010, 0, 1, 16'd2);
        prog_we   = 1'b1;
        tick();
        prog_we = 1'b0;
        checks++; if (instr_out !== 32'h08010001) begin errors++; $display("FAIL collide_ir got %h want 08010001", instr_out); end
        ticks(3);
        checks++; if (dut.u_rf.regs[1] !== 32'd1) begin errors++; $display("FAIL collide_r1_old got %h want 1", dut.u_rf.regs[1]); end
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        ticks(4);
        checks++; if (dut.u_rf.regs[1] !== 32'd2) begin errors++; $display("FAIL collide_r1_new got %h want 2", dut.u_rf.regs[1]); end
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_basic();
        test_sw_lw();
        test_branch();
        test_run_gate();
        test_reset_mid_mem();
        test_r0_nop();
        test_alu_ops();
        test_prog_collision();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
